control_sequencer: RTL
======================

# control_sequencer

Instruction sequencer and microcode decoder for the 4-bit bus CPU.
- Steps through a fixed five-step machine cycle (fetch, then execute) and decodes the instruction register opcode into the per-step control word.
- Drives the program counter (`ce`, `co`, `j`), the MAR, the RAM, the IR, the A/B registers, the ALU, the flags register and the output register.
- Sits directly upstream of the program counter and every other bus participant.

## Interface
Parameters: none. Opcode and step constants live in the shared package.

Ports:
- `clk`  in  1  system clock; all state advances on posedge.
- `reset`  in  1  asynchronous, active-high; clears step and halt state.
- `opcode`  in  4  IR upper nibble, valid from step T2 onward.
- `carry_flag`  in  1  flags register C; exists only with `CONTROLLER_JC_EN`.
- `zero_flag`  in  1  flags register Z; exists only with `CONTROLLER_JC_EN`.
- `step`  out  3  current step, 0..4 (debug/trace).
- `hlt`  out  1  halted; gates the clock upstream.
- `mi`  out  1  MAR in.
- `ri`  out  1  RAM in.
- `ro`  out  1  RAM out.
- `io`  out  1  IR operand (low nibble) out.
- `ii`  out  1  IR in.
- `ai`  out  1  A in.
- `ao`  out  1  A out.
- `eo`  out  1  ALU out.
- `su`  out  1  ALU subtract.
- `bi`  out  1  B in.
- `oi`  out  1  output register in.
- `ce`  out  1  PC count enable.
- `co`  out  1  PC out.
- `j`  out  1  PC in (jump).
- `fi`  out  1  flags in.

## Operation
- Step counter T0→T1→T2→T3→T4→T0; every instruction takes exactly 5 cycles. Unused steps assert nothing.
- Fetch, identical for all opcodes:
  - T0: `co`, `mi`.
  - T1: `ro`, `ii`, `ce`.
- Execute (T2/T3/T4):
  - LDA 0x0: `io mi` / `ro ai` / —
  - ADD 0x1: `io mi` / `ro bi` / `eo ai fi`
  - SUB 0x2: `io mi` / `ro bi` / `eo su ai fi`
  - STA 0x4: `io mi` / `ao ri` / —
  - LDI 0x5: `io ai` / — / —
  - JMP 0x6: `io j` / — / —
  - OUT 0xE: `ao oi` / — / —
  - HLT 0xF: at T2, enter HALT.
- Any other opcode executes as a NOP: fetch, then three empty steps.
- HALT:
  - `hlt` = 1.
  - Step frozen at 2.
  - All other controls 0.
  - Exits only on reset.
- At most one bus driver (`co`, `ro`, `io`, `ao`, `eo`) is high in any step. This is an invariant, checked by assertion.

## Timing
- `step` and the halt bit are registered; the control word is combinational from (`step`, `opcode`, flags). Controls settle within the cycle and are sampled by the datapath at the next posedge.
- Reset asserted:
  - `step` = 0 and the halt bit clears immediately, without waiting for a clock edge.
  - All control outputs, including `hlt`, are forced to 0 while reset is high.
- First posedge after reset deassertion executes T0 (`co`, `mi` high during that cycle).
- Reset mid-instruction aborts the instruction; no partial execute steps complete.
- `opcode` is ignored in T0/T1. A change during T2–T4 takes effect combinationally; the IR must hold it stable.

## Configuration
- `CONTROLLER_JC_EN` defined:
  - Adds ports `carry_flag` and `zero_flag`.
  - JC 0x7: T2 asserts `io`, plus `j` only if `carry_flag` = 1.
  - JZ 0x8: same as JC, conditioned on `zero_flag` = 1.
  - When not taken, T2 is empty and the PC keeps its incremented value.
- Undefined: the flag ports are absent and 0x7/0x8 are NOPs.

## Structure
- Package `cpu_ctrl_pkg`:
  - Opcode localparams (`OP_LDA`…`OP_HLT`, `OP_JC`, `OP_JZ`).
  - Step encodings `T0`..`T4`.
  - Control-word bit indices.
- Sub-module `step_ring`:
  - Inputs: `clk`, `reset`, halt request.
  - Outputs: `step` and the halted flag.
  - Holds the wrap-at-4 logic and halt freeze.
- Top level: the microcode decode only.

## Test plan
- Reset pulse, then 5 clocks, opcode 0x0 → `step` 0,1,2,3,4,0; T0 `co mi`, T1 `ro ii ce`, T2 `io mi`, T3 `ro ai`.
- Opcode 0x2 → T4 asserts `eo su ai fi`; with opcode 0x1, `su` = 0 in T4.
- Opcode 0xF → `hlt` = 1 from T2 onward, step stays at 2 for 10 clocks; reset mid-halt → `hlt` 0 and step 0 without a clock edge.
- Reset asserted during T3 of ADD → all controls 0 at once; after release, T0 restarts.
- With `CONTROLLER_JC_EN`, opcode 0x7: `carry_flag` = 1 → T2 `io j`; `carry_flag` = 0 → T2 empty. JZ is checked the same way with `zero_flag`.
- Sweep all 16 opcodes × 5 steps → exactly one bus driver or none in every step; opcode 0x3 asserts nothing after T1.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared opcode, step and control-word definitions for the 4-bit bus CPU sequencer.
// Conditional jumps (OP_JC/OP_JZ) are decoded only when CONTROLLER_JC_EN is defined.
package cpu_ctrl_pkg;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } step_t;

    localparam int CW_MI    = 0;
    localparam int CW_RI    = 1;
    localparam int CW_RO    = 2;
    localparam int CW_IO    = 3;
    localparam int CW_II    = 4;
    localparam int CW_AI    = 5;
    localparam int CW_AO    = 6;
    localparam int CW_EO    = 7;
    localparam int CW_SU    = 8;
    localparam int CW_BI    = 9;
    localparam int CW_OI    = 10;
    localparam int CW_CE    = 11;
    localparam int CW_CO    = 12;
    localparam int CW_J     = 13;
    localparam int CW_FI    = 14;
    localparam int CW_WIDTH = 15;

    typedef logic [CW_WIDTH-1:0] ctrl_word_t;

    function automatic ctrl_word_t cw_bit(input int idx);
        return ctrl_word_t'(1) << idx;
    endfunction

endpackage

// File: rtl/control_sequencer_step_ring.sv
// Five-step machine-cycle counter with a sticky halt that freezes the step.
//
//   state | meaning
//   T0    | fetch: PC -> MAR
//   T1    | fetch: RAM -> IR, PC++
//   T2    | execute 1 (halt is requested here; frozen here while halted)
//   T3    | execute 2
//   T4    | execute 3, then wrap to T0
module step_ring
    import cpu_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       halt_req,
    output logic [2:0] step,
    output logic       halted
);

    step_t state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= T0;
            halted <= 1'b0;
        end else if (halted || halt_req) begin
            halted <= 1'b1;
        end else begin
            case (state)
                T0:      state <= T1;
                T1:      state <= T2;
                T2:      state <= T3;
                T3:      state <= T4;
                T4:      state <= T0;
                default: state <= T0;
            endcase
        end
    end

    assign step = state;

endmodule

// File: rtl/control_sequencer.sv
// Microcode decoder: maps (step, opcode, flags) to the bus control word each cycle.
// Define CONTROLLER_JC_EN to add carry_flag/zero_flag ports and the JC/JZ opcodes.
module control_sequencer (
    input  logic       clk,
    input  logic       reset,
`ifdef CONTROLLER_JC_EN
    input  logic       carry_flag,
    input  logic       zero_flag,
`endif
    input  logic [3:0] opcode,
    output logic [2:0] step,
    output logic       hlt,
    output logic       mi,
    output logic       ri,
    output logic       ro,
    output logic       io,
    output logic       ii,
    output logic       ai,
    output logic       ao,
    output logic       eo,
    output logic       su,
    output logic       bi,
    output logic       oi,
    output logic       ce,
    output logic       co,
    output logic       j,
    output logic       fi
);
    import cpu_ctrl_pkg::*;

    logic       halted;
    logic       halt_req;
    step_t      cur;
    ctrl_word_t cw;

    assign cur      = step_t'(step);
    assign halt_req = (cur == T2) && (opcode == OP_HLT);

    step_ring u_step_ring (
        .clk      (clk),
        .reset    (reset),
        .halt_req (halt_req),
        .step     (step),
        .halted   (halted)
    );

    always_comb begin
        cw = '0;
        case (cur)
            T0: cw = cw_bit(CW_CO) | cw_bit(CW_MI);
            T1: cw = cw_bit(CW_RO) | cw_bit(CW_II) | cw_bit(CW_CE);
            T2: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: cw = cw_bit(CW_IO) | cw_bit(CW_MI);
                    OP_LDI: cw = cw_bit(CW_IO) | cw_bit(CW_AI);
                    OP_JMP: cw = cw_bit(CW_IO) | cw_bit(CW_J);
`ifdef CONTROLLER_JC_EN
                    // Not-taken branches leave the PC at its T1-incremented value.
                    OP_JC: cw = carry_flag ? (cw_bit(CW_IO) | cw_bit(CW_J)) : ctrl_word_t'(0);
                    OP_JZ: cw = zero_flag  ? (cw_bit(CW_IO) | cw_bit(CW_J)) : ctrl_word_t'(0);
`endif
                    OP_OUT: cw = cw_bit(CW_AO) | cw_bit(CW_OI);
                    default: cw = '0;
                endcase
            end
            T3: begin
                case (opcode)
                    OP_LDA: cw = cw_bit(CW_RO) | cw_bit(CW_AI);
                    OP_ADD, OP_SUB: cw = cw_bit(CW_RO) | cw_bit(CW_BI);
                    OP_STA: cw = cw_bit(CW_AO) | cw_bit(CW_RI);
                    default: cw = '0;
                endcase
            end
            T4: begin
                case (opcode)
                    OP_ADD: cw = cw_bit(CW_EO) | cw_bit(CW_AI) | cw_bit(CW_FI);
                    OP_SUB: cw = cw_bit(CW_EO) | cw_bit(CW_SU) | cw_bit(CW_AI) | cw_bit(CW_FI);
                    default: cw = '0;
                endcase
            end
            default: cw = '0;
        endcase
        if (reset || halted) cw = '0;
    end

    // hlt rises in the T2 cycle itself so the upstream clock gate stops the next edge.
    assign hlt = ~reset & (halted | halt_req);

    assign mi = cw[CW_MI];
    assign ri = cw[CW_RI];
    assign ro = cw[CW_RO];
    assign io = cw[CW_IO];
    assign ii = cw[CW_II];
    assign ai = cw[CW_AI];
    assign ao = cw[CW_AO];
    assign eo = cw[CW_EO];
    assign su = cw[CW_SU];
    assign bi = cw[CW_BI];
    assign oi = cw[CW_OI];
    assign ce = cw[CW_CE];
    assign co = cw[CW_CO];
    assign j  = cw[CW_J];
    assign fi = cw[CW_FI];

    a_one_bus_driver: assert property (@(posedge clk) disable iff (reset)
        $onehot0({co, ro, io, ao, eo}));

endmodule
